// File: rtl/pwm_pkg.sv
// Shared types for the multi-phase PWM generator: dead-time states, carrier
// modes, counter direction and duty-word slicing.
package pwm_pkg;

    typedef enum logic [1:0] {
        DT_OFF = 2'd0,
        DT_HI  = 2'd1,
        DT_LO  = 2'd2
    } dt_state_e;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // LSB of phase ch inside a packed CH*w duty bus
    function automatic int unsigned duty_lsb(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pwm_deadtime_ch.sv
// Per-phase dead-time inserter: turns one raw compare bit into complementary
// high/low gate drives with a programmable both-off gap at every transition.
module pwm_deadtime_ch
    import pwm_pkg::*;
#(
    parameter int unsigned DT_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            raw,
    input  logic [DT_W-1:0] dead_time,
    output logic            pwm_hi,
    output logic            pwm_lo
);

    dt_state_e       state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            tgt_q, tgt_d;
    logic            armed_q, armed_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DT_OFF;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            armed_q <= armed_d;
        end
    end

    // An unarmed channel treats its first raw sample as a change, so the
    // first side after reset/enable also waits out the full dead time.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        armed_d = armed_q;
        if (!enable) begin
            state_d = DT_OFF;
            cnt_d   = '0;
            tgt_d   = 1'b0;
            armed_d = 1'b0;
        end else if (!armed_q || (raw != tgt_q)) begin
            armed_d = 1'b1;
            tgt_d   = raw;
            cnt_d   = dead_time;
            if (dead_time == '0) begin
                state_d = raw ? DT_HI : DT_LO;
            end else begin
                state_d = DT_OFF;
            end
        end else if (state_q == DT_OFF) begin
            if (cnt_q <= DT_W'(1)) begin
                cnt_d   = '0;
                state_d = tgt_q ? DT_HI : DT_LO;
            end else begin
                cnt_d = cnt_q - DT_W'(1);
            end
        end
    end

    always_comb begin
        pwm_hi = (state_q == DT_HI);
        pwm_lo = (state_q == DT_LO);
    end

endmodule

// File: rtl/pwm_gen_multiphase_dt.sv
// Multi-phase PWM generator: shared edge/center carrier, double-buffered
// period/duty/dead-time/mode, and per-phase complementary outputs with dead time.
module pwm_gen_multiphase_dt
    import pwm_pkg::*;
#(
    parameter int unsigned CH   = 3,
    parameter int unsigned W    = 16,
    parameter int unsigned DT_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            center_mode,
    input  logic [W-1:0]    pwm_period,
    input  logic [CH*W-1:0] duty,
    input  logic [DT_W-1:0] dead_time,
    input  logic            load,
    output logic [CH-1:0]   pwm_hi,
    output logic [CH-1:0]   pwm_lo,
    output logic            period_start,
    output logic            load_ack
);

    logic [W-1:0]    cnt_q, cnt_d, cnt_adv;
    pwm_dir_e        dir_q, dir_d, dir_adv;
    logic [W-1:0]    per_s_q, per_s_d;
    logic [CH*W-1:0] duty_s_q, duty_s_d;
    logic [DT_W-1:0] dt_s_q, dt_s_d;
    pwm_mode_e       mode_s_q, mode_s_d;
    logic            pend_q, pend_d;
    logic            pstart_q, pstart_d;
    logic            ack_q, ack_d;
    logic [CH-1:0]   raw_q, raw_d;
    logic            bnd, upd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            per_s_q  <= '0;
            duty_s_q <= '0;
            dt_s_q   <= '0;
            mode_s_q <= MODE_EDGE;
            pend_q   <= 1'b0;
            pstart_q <= 1'b0;
            ack_q    <= 1'b0;
            raw_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            per_s_q  <= per_s_d;
            duty_s_q <= duty_s_d;
            dt_s_q   <= dt_s_d;
            mode_s_q <= mode_s_d;
            pend_q   <= pend_d;
            pstart_q <= pstart_d;
            ack_q    <= ack_d;
            raw_q    <= raw_d;
        end
    end

    // Center mode holds each endpoint for two cycles: the turn-around
    // cycle keeps the count and only flips direction.
    always_comb begin
        cnt_adv = '0;
        dir_adv = DIR_UP;
        if (per_s_q != '0) begin
            if (mode_s_q == MODE_EDGE) begin
                cnt_adv = (cnt_q >= per_s_q - W'(1)) ? '0 : cnt_q + W'(1);
            end else if (dir_q == DIR_UP) begin
                if (cnt_q >= per_s_q - W'(1)) begin
                    cnt_adv = cnt_q;
                    dir_adv = DIR_DOWN;
                end else begin
                    cnt_adv = cnt_q + W'(1);
                end
            end else if (cnt_q != '0) begin
                cnt_adv = cnt_q - W'(1);
                dir_adv = DIR_DOWN;
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        per_s_d  = per_s_q;
        duty_s_d = duty_s_q;
        dt_s_d   = dt_s_q;
        mode_s_d = mode_s_q;
        pend_d   = pend_q;
        pstart_d = 1'b0;
        ack_d    = 1'b0;
        bnd      = (cnt_adv == '0) && (dir_adv == DIR_UP);
        upd      = 1'b0;
        if (!enable) begin
            cnt_d    = '0;
            dir_d    = DIR_UP;
            per_s_d  = pwm_period;
            duty_s_d = duty;
            dt_s_d   = dead_time;
            mode_s_d = pwm_mode_e'(center_mode);
            pend_d   = 1'b0;
        end else begin
            cnt_d  = cnt_adv;
            dir_d  = dir_adv;
            upd    = bnd && (pend_q || load);
            pend_d = (pend_q || load) && !upd;
            if (upd) begin
                per_s_d  = pwm_period;
                duty_s_d = duty;
                dt_s_d   = dead_time;
                mode_s_d = pwm_mode_e'(center_mode);
            end
            pstart_d = bnd && (per_s_d != '0);
            ack_d    = upd;
        end
    end

    // Compare keeps running while disabled so raw is already valid on re-enable.
    always_comb begin
        raw_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            raw_d[i] = (per_s_q != '0) && (cnt_q < duty_s_q[duty_lsb(i, W) +: W]);
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        pwm_deadtime_ch #(
            .DT_W(DT_W)
        ) u_dt (
            .clk       (clk),
            .reset_n   (reset_n),
            .enable    (enable),
            .raw       (raw_q[g]),
            .dead_time (dt_s_q),
            .pwm_hi    (pwm_hi[g]),
            .pwm_lo    (pwm_lo[g])
        );
    end

    assign period_start = pstart_q;
    assign load_ack     = ack_q;

endmodule
